// File: rtl/hazard_ctrl_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_unit_pkg
// Purpose  : Shared encodings, shadow-stage records and match helper for the
//            RV32I pipeline hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_ctrl_unit_pkg;

   localparam logic [1:0] RESULT_LOAD = 2'b01;
   localparam logic [4:0] REG_X0      = 5'd0;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_e;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       regwrite;
      logic       load;
   } e_stage_t;

   typedef struct packed {
      logic [4:0] rd;
      logic       regwrite;
   } wb_stage_t;

   // A producer matches a consumer only if it really writes a non-x0 register.
   function automatic logic fwd_hit(input logic regwrite, input logic [4:0] rd,
                                    input logic [4:0] rs);
      return regwrite && (rd != REG_X0) && (rd == rs);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_unit_if
// Purpose  : Datapath <-> hazard controller bundle (Decode fields in,
//            stall/flush/forward controls and event counters out).
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_unit_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       Rs1D;
   logic [4:0]       Rs2D;
   logic [4:0]       RdD;
   logic             RegWriteD;
   logic [1:0]       ResultSrcD;
   logic             PCSrcE;
   logic             StallF;
   logic             StallD;
   logic             FlushD;
   logic             FlushE;
   logic [1:0]       ForwardAE;
   logic [1:0]       ForwardBE;
   logic [CNT_W-1:0] StallCount;
   logic [CNT_W-1:0] FlushCount;

   modport master (
      output Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCSrcE,
      input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
             StallCount, FlushCount
   );

   modport slave (
      input  Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCSrcE,
      output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
             StallCount, FlushCount
   );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_unit_fwd_select.sv
`default_nettype none
// ============================================================================
// Module   : fwd_select
// Purpose  : Operand bypass select for one Execute source register; the
//            Memory-stage result wins over the Writeback-stage result.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_select (
   input  wire logic [4:0] i_rs,
   input  wire logic [4:0] i_rd_m,
   input  wire logic       i_regwrite_m,
   input  wire logic [4:0] i_rd_w,
   input  wire logic       i_regwrite_w,
   output logic [1:0]      o_sel
);
   import hazard_ctrl_unit_pkg::*;

   always_comb begin
      o_sel = FWD_RF;
      if (fwd_hit(i_regwrite_m, i_rd_m, i_rs)) begin
         o_sel = FWD_M;
      end else if (fwd_hit(i_regwrite_w, i_rd_w, i_rs)) begin
         o_sel = FWD_W;
      end
   end
endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_unit
// Purpose  : 5-stage RV32I hazard controller tracking its own E/M/W shadow of
//            register fields; drives stall, flush, forwarding and counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl_unit #(
   parameter int CNT_W = 16
) (
   input  wire logic         clk,
   input  wire logic         reset,
   hazard_ctrl_unit_if.slave bus
);
   import hazard_ctrl_unit_pkg::*;

   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

   e_stage_t         r_e;
   wb_stage_t        r_m;
   wb_stage_t        r_w;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic             w_lw_stall;
   logic             w_flush_e;
   logic [1:0]       w_fwd_a;
   logic [1:0]       w_fwd_b;

   // Load in E whose result the Decode instruction needs: one bubble cycle.
   assign w_lw_stall = r_e.load && r_e.regwrite && (r_e.rd != REG_X0) &&
                       ((r_e.rd == bus.Rs1D) || (r_e.rd == bus.Rs2D));
   assign w_flush_e  = w_lw_stall || bus.PCSrcE;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_e         <= '0;
         r_m         <= '0;
         r_w         <= '0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_flush_e) begin
            r_e <= '0;
         end else begin
            r_e.rs1      <= bus.Rs1D;
            r_e.rs2      <= bus.Rs2D;
            r_e.rd       <= bus.RdD;
            r_e.regwrite <= bus.RegWriteD;
            r_e.load     <= (bus.ResultSrcD == RESULT_LOAD);
         end
         r_m.rd       <= r_e.rd;
         r_m.regwrite <= r_e.regwrite;
         r_w          <= r_m;
         if (w_lw_stall && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + c_cnt_one;
         end
         if (bus.PCSrcE && (r_flush_cnt != c_cnt_max)) begin
            r_flush_cnt <= r_flush_cnt + c_cnt_one;
         end
      end
   end

   fwd_select u_fwd_a (
      .i_rs         (r_e.rs1),
      .i_rd_m       (r_m.rd),
      .i_regwrite_m (r_m.regwrite),
      .i_rd_w       (r_w.rd),
      .i_regwrite_w (r_w.regwrite),
      .o_sel        (w_fwd_a)
   );

   fwd_select u_fwd_b (
      .i_rs         (r_e.rs2),
      .i_rd_m       (r_m.rd),
      .i_regwrite_m (r_m.regwrite),
      .i_rd_w       (r_w.rd),
      .i_regwrite_w (r_w.regwrite),
      .o_sel        (w_fwd_b)
   );

   assign bus.StallF     = w_lw_stall;
   assign bus.StallD     = w_lw_stall;
   assign bus.FlushD     = bus.PCSrcE;
   assign bus.FlushE     = w_flush_e;
   assign bus.ForwardAE  = w_fwd_a;
   assign bus.ForwardBE  = w_fwd_b;
   assign bus.StallCount = r_stall_cnt;
   assign bus.FlushCount = r_flush_cnt;
endmodule
`default_nettype wire

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Pipeline hazard controller for the 5-stage RV32I core (F/D/E/M/W).
- Keeps its own shadow copy of the register-address and control fields as they move from Decode through Writeback.
- Produces the stall, flush and forwarding selects. FlushE is the bubble request that squashes the Execute control bundle.
- Sits beside the datapath and takes only Decode-stage fields plus the Execute branch/jump decision. The D/E/M/W register fields are never wired back to it.

Parameters:
- CNT_W, 16, width of the saturating stall and flush event counters.

Ports:
- clk  in  1  core clock
- reset  in  1  reset; one clock, reset synchronous active-high
- Rs1D  in  5  source register 1 of the Decode instruction
- Rs2D  in  5  source register 2 of the Decode instruction
- RdD  in  5  destination register of the Decode instruction
- RegWriteD  in  1  Decode instruction writes the register file
- ResultSrcD  in  2  Decode result select; 2'b01 = load
- PCSrcE  in  1  branch taken or jump in Execute
- StallF  out  1  hold PC
- StallD  out  1  hold the F/D register
- FlushD  out  1  clear the F/D register
- FlushE  out  1  bubble the D/E register (zero the control bundle)
- ForwardAE  out  2  SrcA select: 00 register file, 01 W result, 10 M ALU result
- ForwardBE  out  2  SrcB select, same encoding as ForwardAE
- StallCount  out  CNT_W  load-use stall cycles since reset, saturating
- FlushCount  out  CNT_W  control-flush cycles since reset, saturating

Behaviour:
- Shadow registers: Rs1E, Rs2E, RdE, RegWriteE, LoadE, RdM, RegWriteM, RdW, RegWriteW.
- Shadow update each rising edge:
  - If FlushE=1, the E stage loads zeros (a bubble).
  - Otherwise the E stage captures the D inputs; LoadE = (ResultSrcD==2'b01).
  - M captures E and W captures M unconditionally.
- Reset: all shadow registers and both counters clear to 0 on the edge where reset=1.
  - With shadows at 0, all stall/flush/forward outputs read 0 in the cycle after reset, apart from the combinational D-input terms.
  - Reset arriving mid-stall or mid-flush overrides everything; no stall or bubble carries over.
- lwStall = LoadE & RegWriteE & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D). Combinational, same cycle.
- StallF = StallD = lwStall. FlushD = PCSrcE. FlushE = lwStall | PCSrcE.
- PCSrcE and lwStall in the same cycle: both apply. FlushD=1, FlushE=1, StallF=StallD=1. The datapath gives the flush priority at the F/D register.
- ForwardAE:
  - 10 if RegWriteM & RdM!=0 & RdM==Rs1E;
  - else 01 if RegWriteW & RdW!=0 & RdW==Rs1E;
  - else 00.
  - M has priority over W when both match.
  - Register x0 never forwards.
- ForwardBE: identical, using Rs2E.
- Forward outputs depend only on registered shadow state, so they are glitch-free at the start of the cycle.
- Latency:
  - Stall/flush decisions are same-cycle combinational.
  - A load-use stall lasts exactly 1 cycle, because the bubble inserted into E clears LoadE.
  - A taken branch flushes D and E for 1 cycle.
- Counters:
  - StallCount += 1 on each cycle with lwStall=1.
  - FlushCount += 1 on each cycle with PCSrcE=1.
  - Both hold at 2^CNT_W-1; there is no wrap.
  - A cycle with both events increments both counters.
- A load to x0 never stalls. A non-load writer in E never stalls; forwarding covers it.

Decomposition:
- Shared package constants:
  - RESULT_LOAD = 2'b01
  - FWD_RF = 2'b00
  - FWD_W = 2'b01
  - FWD_M = 2'b10
  - REG_X0 = 5'd0
- One natural sub-module: fwd_select. It compares one source register against the M and W shadows and returns a 2-bit select. It is instantiated twice, for A and B.
- The counters stay inline.

Test Plan:
- Reset held 3 cycles with random D inputs -> all outputs 0 after release, StallCount=FlushCount=0.
- lw x5 (RdD=5, ResultSrcD=01, RegWriteD=1), next add Rs1D=5 -> that cycle StallF=StallD=FlushE=1. Next cycle stall=0, ForwardAE=01 with lw in W. StallCount=1.
- add x3; then sub Rs1D=3, Rs2D=3 -> ForwardAE=ForwardBE=10 when sub is in E. With an add x3 in M and an older add x3 in W -> still 10 (M priority).
- Writer RdD=0 with RegWriteD=1, then reader Rs1D=0 -> ForwardAE=00, no stall.
- PCSrcE=1 for one cycle coincident with a load-use hazard -> FlushD=FlushE=StallF=1. StallCount and FlushCount both +1. E is a bubble next cycle.
- CNT_W=2, 5 back-to-back load-use pairs -> StallCount saturates at 3. Assert reset mid-stall -> counters 0 and StallF=0 next cycle.
